mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between a CPU data port and a DMA
// port. The CPU normally has priority. A DMA request that has been refused for
// MAX_WAIT cycles is forced through. Once the DMA holds the port it may run up to
// BURST_LEN beats back to back before it has to re-arbitrate against the CPU.
module mem_port_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en_i,
    input  logic [3:0]  cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic        cpu_stall_o,
    output logic [31:0] cpu_data_o,
    input  logic        dma_req_i,
    input  logic [3:0]  dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_data_i,
    output logic        dma_gnt_o,
    output logic [31:0] dma_data_o,
    output logic        dma_rvalid_o,
    output logic        mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    localparam logic [0:0] S_CPU = 1'b0;
    localparam logic [0:0] S_DMA = 1'b1;

    localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
    localparam logic [3:0] BURST_LEN_C = 4'(BURST_LEN);

    logic [0:0] state_r;
    logic [0:0] state_nxt_s;
    logic [3:0] wait_cnt_r;
    logic [3:0] wait_nxt_s;
    logic [3:0] beat_cnt_r;
    logic [3:0] beat_nxt_s;
    logic       rd_owner_r;
    logic       arb_gnt_s;
    logic       gnt_s;
    logic       mem_en_s;

    // Arbitration decision and next-state / counter computation
    always_comb begin
        arb_gnt_s   = 1'b0;
        state_nxt_s = state_r;
        wait_nxt_s  = 4'd0;
        beat_nxt_s  = beat_cnt_r;
        case (state_r)
            S_CPU: begin
                if (dma_req_i && (!cpu_en_i || (wait_cnt_r == MAX_WAIT_C))) begin
                    arb_gnt_s   = 1'b1;
                    state_nxt_s = S_DMA;
                    beat_nxt_s  = 4'd1;
                    wait_nxt_s  = 4'd0;
                end else if (dma_req_i) begin
                    // Refused DMA ages toward its forced grant, saturating.
                    wait_nxt_s = (wait_cnt_r == MAX_WAIT_C) ? MAX_WAIT_C : (wait_cnt_r + 4'd1);
                    beat_nxt_s = 4'd0;
                end else begin
                    wait_nxt_s = 4'd0;
                    beat_nxt_s = 4'd0;
                end
            end
            S_DMA: begin
                wait_nxt_s = 4'd0;
                if (beat_cnt_r < BURST_LEN_C) begin
                    if (dma_req_i) begin
                        arb_gnt_s  = 1'b1;
                        beat_nxt_s = beat_cnt_r + 4'd1;
                    end else begin
                        state_nxt_s = S_CPU;
                        beat_nxt_s  = 4'd0;
                    end
                end else begin
                    // Burst exhausted: re-arbitrate as a fresh CPU-state cycle
                    // with no accumulated wait, so the CPU wins if it asks.
                    if (dma_req_i && !cpu_en_i) begin
                        arb_gnt_s  = 1'b1;
                        beat_nxt_s = 4'd1;
                    end else begin
                        state_nxt_s = S_CPU;
                        beat_nxt_s  = 4'd0;
                    end
                end
            end
            default: begin
                state_nxt_s = S_CPU;
                wait_nxt_s  = 4'd0;
                beat_nxt_s  = 4'd0;
            end
        endcase
    end

    assign gnt_s    = arb_gnt_s && !reset;
    assign mem_en_s = !reset && (gnt_s || cpu_en_i);

    // Arbiter state, counters and read-ownership tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_CPU;
            wait_cnt_r <= 4'd0;
            beat_cnt_r <= 4'd0;
            rd_owner_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            beat_cnt_r <= beat_nxt_s;
            rd_owner_r <= gnt_s && (dma_we_i == 4'd0);
        end
    end

    // Memory request mux: the winner drives the port, everything zero when idle
    always_comb begin
        mem_we_o   = 4'd0;
        mem_addr_o = 32'd0;
        mem_data_o = 32'd0;
        if (gnt_s) begin
            mem_we_o   = dma_we_i;
            mem_addr_o = dma_addr_i;
            mem_data_o = dma_data_i;
        end else if (mem_en_s) begin
            mem_we_o   = cpu_we_i;
            mem_addr_o = cpu_addr_i;
            mem_data_o = cpu_data_i;
        end else begin
            mem_we_o   = 4'd0;
            mem_addr_o = 32'd0;
            mem_data_o = 32'd0;
        end
    end

    assign mem_en_o     = mem_en_s;
    assign dma_gnt_o    = gnt_s;
    assign cpu_stall_o  = cpu_en_i && gnt_s;
    assign dma_rvalid_o = rd_owner_r && !reset;
    assign cpu_data_o   = mem_data_i;
    assign dma_data_o   = mem_data_i;

endmodule
